// File: rtl/conv_row_collector.sv
// Collects OW-pixel convolution rows into an OH x OW feature map and holds the
// completed map on frame_out_o until the consumer acknowledges it.
module conv_row_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int IDXW       = 6
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [(W-F+1)*DATA_WIDTH-1:0]           row_in_i,
  input  logic                                    row_valid_i,
  output logic                                    row_ready_o,
  input  logic                                    index_mode_i,
  input  logic [IDXW-1:0]                         row_index_i,
  output logic [(H-F+1)*(W-F+1)*DATA_WIDTH-1:0]   frame_out_o,
  output logic                                    frame_valid_o,
  input  logic                                    frame_ack_i,
  output logic [IDXW:0]                           rows_filled_o,
  output logic                                    err_index_o
);

  localparam int OH    = H - F + 1;
  localparam int OW    = W - F + 1;
  localparam int ROW_W = OW * DATA_WIDTH;

  // state  | meaning
  // S_FILL | accepting rows until every mask bit is set
  // S_HOLD | map complete and frozen, waiting for frame_ack_i
  typedef enum logic {S_FILL, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [OH-1:0]     written_q, written_d;
  logic [IDXW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IDXW:0]     rows_filled_q, rows_filled_d;
  logic              err_q, err_d;
  logic [ROW_W-1:0]  rows_q [OH];

  logic              accept;
  logic [IDXW-1:0]   idx;
  logic              idx_ok;
  logic [OH-1:0]     row_sel;
  logic              new_row;

  assign accept  = row_valid_i && (state_q == S_FILL);
  assign idx     = index_mode_i ? row_index_i : wr_ptr_q;
  assign idx_ok  = (idx < IDXW'(OH));
  // One-hot row decode avoids indexing the mask with an out-of-range index.
  assign row_sel = idx_ok ? (OH'(1) << idx) : '0;
  assign new_row = |(row_sel & ~written_q);

  always_comb begin
    state_d       = state_q;
    written_d     = written_q;
    wr_ptr_d      = wr_ptr_q;
    rows_filled_d = rows_filled_q;
    err_d         = 1'b0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          if (idx_ok) begin
            written_d = written_q | row_sel;
            if (new_row) rows_filled_d = rows_filled_q + (IDXW+1)'(1);
            if (!index_mode_i) wr_ptr_d = wr_ptr_q + IDXW'(1);
            if (&written_d) state_d = S_HOLD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (frame_ack_i) begin
          state_d       = S_FILL;
          written_d     = '0;
          wr_ptr_d      = '0;
          rows_filled_d = '0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_FILL;
      written_q     <= '0;
      wr_ptr_q      <= '0;
      rows_filled_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      written_q     <= written_d;
      wr_ptr_q      <= wr_ptr_d;
      rows_filled_q <= rows_filled_d;
      err_q         <= err_d;
    end
  end

  for (genvar r = 0; r < OH; r++) begin : g_row
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rows_q[r] <= '0;
      end else if (accept && row_sel[r]) begin
        rows_q[r] <= row_in_i;
      end
    end
    assign frame_out_o[r*ROW_W +: ROW_W] = rows_q[r];
  end

  assign row_ready_o   = (state_q == S_FILL);
  assign frame_valid_o = (state_q == S_HOLD);
  assign rows_filled_o = rows_filled_q;
  assign err_index_o   = err_q;

endmodule

// File: tb/tb_conv_row_collector.sv
// Directed self-checking bench for conv_row_collector.
module tb_conv_row_collector;

  localparam int DW   = 32;
  localparam int H    = 32;
  localparam int W    = 32;
  localparam int F    = 5;
  localparam int IDXW = 6;
  localparam int OH   = H - F + 1;
  localparam int OW   = W - F + 1;
  localparam int ROW_W = OW * DW;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [ROW_W-1:0]       row_in_i;
  logic                   row_valid_i;
  logic                   row_ready_o;
  logic                   index_mode_i;
  logic [IDXW-1:0]        row_index_i;
  logic [OH*ROW_W-1:0]    frame_out_o;
  logic                   frame_valid_o;
  logic                   frame_ack_i;
  logic [IDXW:0]          rows_filled_o;
  logic                   err_index_o;

  int tests = 0;
  int fails = 0;
  int exp_base [OH];

  always #5 clk_i = ~clk_i;

  conv_row_collector #(.DATA_WIDTH(DW), .H(H), .W(W), .F(F), .IDXW(IDXW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .row_in_i(row_in_i), .row_valid_i(row_valid_i),
    .row_ready_o(row_ready_o), .index_mode_i(index_mode_i), .row_index_i(row_index_i),
    .frame_out_o(frame_out_o), .frame_valid_o(frame_valid_o), .frame_ack_i(frame_ack_i),
    .rows_filled_o(rows_filled_o), .err_index_o(err_index_o)
  );

  function automatic logic [31:0] pix(int base, int p);
    return 32'((base << 8) | p);
  endfunction

  // Pixel 0 sits in the MSBs of the row.
  function automatic logic [ROW_W-1:0] mk_row(int base);
    logic [ROW_W-1:0] r;
    for (int p = 0; p < OW; p++) r[(OW-1-p)*DW +: DW] = pix(base, p);
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(string tag);
    for (int r = 0; r < OH; r++) begin
      int bad = 0;
      logic [31:0] o;
      for (int p = OW-1; p >= 0; p--)
        if (frame_out_o[r*ROW_W + (OW-1-p)*DW +: DW] !== pix(exp_base[r], p)) bad = p;
      o = frame_out_o[r*ROW_W + (OW-1-bad)*DW +: DW];
      check($sformatf("%s row%0d pix%0d", tag, r, bad), {32'd0, o}, {32'd0, pix(exp_base[r], bad)});
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; row_in_i = '0; row_valid_i = 1'b0; index_mode_i = 1'b0;
    row_index_i = '0; frame_ack_i = 1'b0;
    step(); step();
    check("rst ready", {63'd0, row_ready_o}, 64'd1);
    check("rst fvalid", {63'd0, frame_valid_o}, 64'd0);
    check("rst filled", {57'd0, rows_filled_o}, 64'd0);
    check("rst err", {63'd0, err_index_o}, 64'd0);
    check("rst frame", {63'd0, |frame_out_o}, 64'd0);
    rst_ni = 1'b1;
    step();

    // 1: sequential fill
    row_valid_i = 1'b1;
    for (int r = 0; r < OH; r++) begin
      row_in_i = mk_row(r); exp_base[r] = r;
      step();
      if (r == OH-2) check("seq fvalid early", {63'd0, frame_valid_o}, 64'd0);
    end
    check("seq fvalid", {63'd0, frame_valid_o}, 64'd1);
    check("seq filled", {57'd0, rows_filled_o}, 64'd28);
    check_frame("seq");

    // 2: hold ignores rows, then ack
    row_in_i = mk_row(99);
    step(); step(); step();
    check("hold ready", {63'd0, row_ready_o}, 64'd0);
    check("hold fvalid", {63'd0, frame_valid_o}, 64'd1);
    check("hold filled", {57'd0, rows_filled_o}, 64'd28);
    check_frame("hold");
    row_valid_i = 1'b0; frame_ack_i = 1'b1;
    step();
    frame_ack_i = 1'b0;
    check("ack fvalid", {63'd0, frame_valid_o}, 64'd0);
    check("ack ready", {63'd0, row_ready_o}, 64'd1);
    check("ack filled", {57'd0, rows_filled_o}, 64'd0);
    check_frame("ack keep");
    frame_ack_i = 1'b1; step(); frame_ack_i = 1'b0;
    check("ack in fill", {63'd0, row_ready_o}, 64'd1);

    // 3: indexed reverse order
    index_mode_i = 1'b1; row_valid_i = 1'b1;
    for (int i = OH-1; i >= 0; i--) begin
      row_index_i = IDXW'(i); row_in_i = mk_row(100 + i); exp_base[i] = 100 + i;
      step();
      if (i == 1) check("idx fvalid early", {63'd0, frame_valid_o}, 64'd0);
    end
    row_valid_i = 1'b0;
    check("idx fvalid", {63'd0, frame_valid_o}, 64'd1);
    check("idx filled", {57'd0, rows_filled_o}, 64'd28);
    check_frame("idx");
    frame_ack_i = 1'b1; step(); frame_ack_i = 1'b0;

    // 4: overwrite and out-of-range index
    row_valid_i = 1'b1; row_index_i = 6'd5; row_in_i = mk_row(8'hAA);
    step();
    check("ow filled1", {57'd0, rows_filled_o}, 64'd1);
    row_in_i = mk_row(8'hBB); exp_base[5] = 8'hBB;
    step();
    check("ow filled2", {57'd0, rows_filled_o}, 64'd1);
    check("ow err0", {63'd0, err_index_o}, 64'd0);
    check_frame("ow");
    row_index_i = 6'd40; row_in_i = mk_row(77);
    step();
    check("err pulse", {63'd0, err_index_o}, 64'd1);
    check("err filled", {57'd0, rows_filled_o}, 64'd1);
    row_valid_i = 1'b0;
    step();
    check("err clear", {63'd0, err_index_o}, 64'd0);
    check_frame("err nochg");
    // Sequential rows after indexed ones: pointer must still start at 0.
    index_mode_i = 1'b0; row_valid_i = 1'b1;
    for (int r = 0; r < OH; r++) begin
      row_in_i = mk_row(500 + r); exp_base[r] = 500 + r;
      step();
      if (r == 4 || r == 5) check($sformatf("mix filled r%0d", r), {57'd0, rows_filled_o}, 64'd6);
      if (r == OH-2) check("mix fvalid early", {63'd0, frame_valid_o}, 64'd0);
    end
    row_valid_i = 1'b0;
    check("mix fvalid", {63'd0, frame_valid_o}, 64'd1);
    check_frame("mix");
    frame_ack_i = 1'b1; step(); frame_ack_i = 1'b0;

    // 5: reset mid-frame
    row_valid_i = 1'b1;
    for (int r = 0; r < 10; r++) begin
      row_in_i = mk_row(200 + r);
      step();
    end
    check("mid filled", {57'd0, rows_filled_o}, 64'd10);
    rst_ni = 1'b0;
    #1;
    check("mrst filled", {57'd0, rows_filled_o}, 64'd0);
    check("mrst frame", {63'd0, |frame_out_o}, 64'd0);
    check("mrst fvalid", {63'd0, frame_valid_o}, 64'd0);
    check("mrst ready", {63'd0, row_ready_o}, 64'd1);
    check("mrst err", {63'd0, err_index_o}, 64'd0);
    step();
    rst_ni = 1'b1;
    for (int r = 0; r < OH; r++) begin
      row_in_i = mk_row(300 + r); exp_base[r] = 300 + r;
      step();
    end
    row_valid_i = 1'b0;
    check("post fvalid", {63'd0, frame_valid_o}, 64'd1);
    check("post filled", {57'd0, rows_filled_o}, 64'd28);
    check_frame("post");
    frame_ack_i = 1'b1; step(); frame_ack_i = 1'b0;

    // 6: gapped valid, sequential
    begin
      int acc = 0;
      int cyc = 0;
      while (acc < OH && cyc < 200) begin
        row_valid_i = ((cyc % 5) != 1) && ((cyc % 7) != 3);
        row_in_i = mk_row(400 + acc);
        step();
        if (row_valid_i) begin
          exp_base[acc] = 400 + acc;
          acc++;
          if (acc == OH-1) check("gap fvalid early", {63'd0, frame_valid_o}, 64'd0);
        end
        cyc++;
      end
      row_valid_i = 1'b0;
      check("gap accepts", 64'(acc), 64'(OH));
      check("gap fvalid", {63'd0, frame_valid_o}, 64'd1);
      check("gap filled", {57'd0, rows_filled_o}, 64'd28);
      check_frame("gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
